// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   localparam int DATA_W_DEF = 8;

   function automatic int id_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational rotate-priority search: first set request at or above ptr_i, with wrap.
module fifo_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic               found_o,
   output logic [ID_W-1:0]    idx_o
);

   // Walk offsets from farthest to nearest so the nearest hit wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int c;
         c = int'(ptr_i) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         if (req_i[c]) begin
            found_o = 1'b1;
            idx_o   = ID_W'(c);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = DATA_W_DEF,
   parameter  int MAX_BURST = 4,
   localparam int ID_W      = id_w(NUM_REQ),
   localparam int CNT_W     = cnt_w(MAX_BURST)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic                      fifo_full_i,
   output logic                      fifo_wr_en_o,
   output logic [DATA_W-1:0]         fifo_data_o,
   output logic                      grant_valid_o,
   output logic [ID_W-1:0]           grant_id_o
);

   arb_state_e       state_q;
   logic [ID_W-1:0]  grant_id_q;
   logic             grant_valid_q;
   logic [ID_W-1:0]  rr_ptr_q;
   logic [ID_W-1:0]  rr_ptr_d;
   logic [CNT_W-1:0] beat_cnt_q;
   logic [CNT_W-1:0] beat_cnt_d;

   logic             pick_found;
   logic [ID_W-1:0]  pick_idx;
   logic             gnt_valid;
   logic [DATA_W-1:0] gnt_data;
   logic             xfer;
   logic             burst_end;

   fifo_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      gnt_valid   = 1'b0;
      gnt_data    = '0;
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == ID_W'(i)) begin
            gnt_valid      = req_valid_i[i];
            gnt_data       = req_data_i[i*DATA_W +: DATA_W];
            req_ready_o[i] = grant_valid_q && !fifo_full_i;
         end
      end
   end

   assign xfer      = grant_valid_q && gnt_valid && !fifo_full_i;
   assign burst_end = grant_valid_q &&
                      (!gnt_valid || (xfer && beat_cnt_q == CNT_W'(MAX_BURST - 1)));
   assign beat_cnt_d = xfer ? beat_cnt_q + 1'b1 : beat_cnt_q;
   // Explicit wrap keeps non-power-of-2 NUM_REQ in range.
   assign rr_ptr_d  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

   assign fifo_wr_en_o  = xfer;
   assign fifo_data_o   = grant_valid_q ? gnt_data : '0;
   assign grant_valid_o = grant_valid_q;
   assign grant_id_o    = grant_id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         rr_ptr_q      <= '0;
         beat_cnt_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_found) begin
                  grant_id_q    <= pick_idx;
                  grant_valid_q <= 1'b1;
                  beat_cnt_q    <= '0;
                  state_q       <= ST_BURST;
               end
            end
            ST_BURST: begin
               beat_cnt_q <= beat_cnt_d;
               if (burst_end) begin
                  state_q       <= ST_IDLE;
                  grant_valid_q <= 1'b0;
                  rr_ptr_q      <= rr_ptr_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of one 8-bit synchronous FIFO among NUM_REQ producers. Each producer has a valid/ready handshake. Grants rotate round-robin, and a grant is held for a burst of up to MAX_BURST beats. The block sits directly in front of the FIFO: it drives the FIFO's wr_en/data_in and observes its full flag. The FIFO read side is untouched.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_W, 8, data width per producer and to the FIFO
MAX_BURST, 4, maximum beats per grant (1..16)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-producer data valid
req_data  in  NUM_REQ*DATA_W  producer i occupies bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  per-producer accept; one-hot or zero
fifo_full  in  1  FIFO full flag, reflecting current contents
fifo_wr_en  out  1  FIFO write enable
fifo_data  out  DATA_W  FIFO write data
grant_valid  out  1  a producer currently holds the grant
grant_id  out  clog2(NUM_REQ)  index of the granted producer

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, grant_id=0, grant_valid=0, rr_ptr=0, beat_cnt=0.
  - req_ready=0, fifo_wr_en=0, fifo_data=0.
  - Takes effect immediately, including mid-burst. Any in-flight beat is not written.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is high, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
  - Register grant_id, set grant_valid=1, set beat_cnt=0, go to BURST.
  - Arbitration costs exactly one cycle; no transfer occurs in IDLE.
- BURST outputs (combinational from registered grant):
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0.
  - A transfer is req_valid[grant_id] && req_ready[grant_id].
  - fifo_wr_en = transfer.
  - fifo_data = granted slice of req_data when grant_valid, else 0.
- BURST transitions:
  - On a transfer: beat_cnt++. If beat_cnt was MAX_BURST-1, the burst ends.
  - If req_valid[grant_id]=0: the burst ends that cycle with no transfer.
  - If fifo_full=1 while valid is high: stall. Grant is held, beat_cnt is unchanged, and the burst does not end on a stall alone.
  - On burst end: state goes to IDLE, grant_valid goes to 0, rr_ptr becomes (grant_id+1) mod NUM_REQ.
- Boundaries:
  - Every regrant passes through IDLE, so there is one bubble cycle between bursts, even for the same producer.
  - A lone requester is regranted after its own burst ends (rr_ptr wraps past idle producers).
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Non-granted producers' valid and data are ignored. A producer must hold valid and data until it sees ready.
  - fifo_full is sampled combinationally each cycle. The arbiter never asserts fifo_wr_en while fifo_full=1, so there is no write drop.
- Widths:
  - beat_cnt has width clog2(MAX_BURST+1).
  - rr_ptr and grant_id have width clog2(NUM_REQ).
  - Modulo wrap is explicit for non-power-of-2 NUM_REQ.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - the ID_W and CNT_W localparam functions;
  - a DATA_W default constant shared with the FIFO.
- One sub-module is natural: fifo_rr_picker.
  - Purely combinational rotate-priority search.
  - Inputs: req vector, rr_ptr. Outputs: found, idx.
  - The parent holds all state.

Test Plan:
1. Reset, then producer 0 holds valid with data 0x10..0x15 (6 beats) and fifo_full=0 -> writes 0x10-0x13, one IDLE cycle, regrant to 0, writes 0x14-0x15, then grant_valid=0.
2. All four producers are continuously valid -> grant_id sequence 0,1,2,3,0. Each burst is 4 writes with one bubble between bursts. The fifo_wr_en duty cycle is 4/5.
3. Producer 2 is mid-burst after 2 beats; fifo_full is raised for 3 cycles -> req_ready=0 and fifo_wr_en=0 for 3 cycles, grant_id stays 2, then 2 more beats are written.
4. Producer 1 drops valid after beat 1 while producer 3 is valid -> burst ends, IDLE, grant goes to 3 (rr_ptr=2 is skipped because producer 2 is idle).
5. rst_n is pulsed low asynchronously mid-cycle during a burst -> all outputs are 0 immediately. After release, the first grant goes to the lowest valid index starting from 0.
6. Only producer 3 is valid at rr_ptr=3 -> it is granted, and after the burst rr_ptr wraps to 0 and producer 3 is regranted.
